ttl_sr_latch_sync: RTL and testbench

// - Clocked, parametrised array of NOR-type set/reset latches. It generalises the

---
 rtl/ttl_sr_latch_sync.sv | 101 ++++++++++
 tb/tb_ttl_sr_latch_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ttl_sr_latch_sync.sv
// Clocked array of NOR-type S/R latches (7402/74279 style) with OR-ed multi-input set/reset,
// deterministic S=R=1 release handling and a configurable output delay pipeline.
module ttl_sr_latch_sync #(
    parameter int unsigned BLOCKS   = 4,
    parameter int unsigned WIDTH_IN = 2,
    parameter int unsigned LATENCY  = 1
) (
    input  logic                         Clk,
    input  logic                         Clear,
    input  logic                         Enable,
    input  logic [BLOCKS*WIDTH_IN-1:0]   S_2D,
    input  logic [BLOCKS*WIDTH_IN-1:0]   R_2D,
    output logic [BLOCKS-1:0]            Q,
    output logic [BLOCKS-1:0]            Q_bar,
    output logic [BLOCKS-1:0]            Invalid
);

    localparam int unsigned W = 3 * BLOCKS;
    localparam logic [W-1:0] RST_WORD = {{BLOCKS{1'b0}}, {BLOCKS{1'b1}}, {BLOCKS{1'b0}}};

    typedef enum logic [1:0] {StReset, StSet, StBoth, StInvalid} state_t;

    if (LATENCY == 0 || LATENCY > 4) begin : g_bad_latency
        $error("ttl_sr_latch_sync: LATENCY must be in 1..4");
    end

    logic [BLOCKS-1:0] q0, qb0, inv0;

    for (genvar i = 0; i < BLOCKS; i++) begin : g_blk
        logic [WIDTH_IN-1:0] s_vec, r_vec;
        logic                s, r;
        logic                q_b, qb_b, inv_b;
        state_t              state_q, state_d;

        for (genvar j = 0; j < WIDTH_IN; j++) begin : g_in
            assign s_vec[j] = S_2D[j*BLOCKS+i];
            assign r_vec[j] = R_2D[j*BLOCKS+i];
        end

        assign s = |s_vec;
        assign r = |r_vec;

        // Unknown s/r propagates as an unknown state rather than being resolved silently.
        always_comb begin
            state_d = state_q;
            if (Enable) begin
                case ({s, r})
                    2'b10:   state_d = StSet;
                    2'b01:   state_d = StReset;
                    2'b11:   state_d = StBoth;
                    2'b00:   if (state_q == StBoth) state_d = StInvalid;
                    default: state_d = state_t'(2'bxx);
                endcase
            end
        end

        always_ff @(posedge Clk) begin
            if (Clear) state_q <= StReset;
            else       state_q <= state_d;
        end

        always_comb begin
            q_b   = 1'b0;
            qb_b  = 1'b1;
            inv_b = 1'b0;
            case (state_q)
                StSet: begin
                    q_b  = 1'b1;
                    qb_b = 1'b0;
                end
                StBoth:    qb_b  = 1'b0;
                StInvalid: inv_b = 1'b1;
                default: ;
            endcase
        end

        assign q0[i]   = q_b;
        assign qb0[i]  = qb_b;
        assign inv0[i] = inv_b;
    end

    if (LATENCY <= 1) begin : g_direct
        assign {Q, Q_bar, Invalid} = {q0, qb0, inv0};
    end else begin : g_pipe
        logic [W-1:0] stg [LATENCY-1];

        for (genvar k = 0; k < LATENCY - 1; k++) begin : g_stage
            always_ff @(posedge Clk) begin
                if (Clear) begin
                    stg[k] <= RST_WORD;
                end else begin
                    if (k == 0) stg[k] <= {q0, qb0, inv0};
                    else        stg[k] <= stg[(k == 0) ? 0 : k-1];
                end
            end
        end

        assign {Q, Q_bar, Invalid} = stg[LATENCY-2];
    end

endmodule

// File: tb/tb_ttl_sr_latch_sync.sv
// Bench for ttl_sr_latch_sync: directed vector table on LATENCY=2, hand sequences for
// LATENCY=1/3, and random stimulus checked against a behavioural model on all three.
module tb_ttl_sr_latch_sync;

    logic       Clk = 1'b0;
    logic       Clear, Enable;
    logic [7:0] S_2D, R_2D;
    logic [3:0] q1, qb1, inv1, q2, qb2, inv2, q3, qb3, inv3;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ttl_sr_latch_sync #(.BLOCKS(4), .WIDTH_IN(2), .LATENCY(1)) dut1 (
        .Clk(Clk), .Clear(Clear), .Enable(Enable), .S_2D(S_2D), .R_2D(R_2D),
        .Q(q1), .Q_bar(qb1), .Invalid(inv1));
    ttl_sr_latch_sync #(.BLOCKS(4), .WIDTH_IN(2), .LATENCY(2)) dut2 (
        .Clk(Clk), .Clear(Clear), .Enable(Enable), .S_2D(S_2D), .R_2D(R_2D),
        .Q(q2), .Q_bar(qb2), .Invalid(inv2));
    ttl_sr_latch_sync #(.BLOCKS(4), .WIDTH_IN(2), .LATENCY(3)) dut3 (
        .Clk(Clk), .Clear(Clear), .Enable(Enable), .S_2D(S_2D), .R_2D(R_2D),
        .Q(q3), .Q_bar(qb3), .Invalid(inv3));

    // Model: per-block state as a name-like int, output history newest-first.
    localparam int M_RST = 0, M_SET = 1, M_BOTH = 2, M_INV = 3;
    localparam logic [11:0] RST_WORD = {4'h0, 4'hF, 4'h0};
    int          st [4];
    logic [11:0] hist [$];
    bit          model_valid = 0;

    function automatic logic [11:0] enc();
        logic [3:0] q, qb, inv;
        for (int b = 0; b < 4; b++) begin
            q[b]   = (st[b] == M_SET);
            qb[b]  = !(st[b] == M_SET || st[b] == M_BOTH);
            inv[b] = (st[b] == M_INV);
        end
        return {q, qb, inv};
    endfunction

    task automatic model_edge(input logic clr, input logic en, input logic [7:0] s,
                              input logic [7:0] r);
        bit sb, rb;
        if (clr) begin
            for (int b = 0; b < 4; b++) st[b] = M_RST;
            hist.delete();
            repeat (4) hist.push_front(RST_WORD);
            model_valid = 1;
            return;
        end
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                sb = s[b] || s[b+4];
                rb = r[b] || r[b+4];
                if (sb && rb)              st[b] = M_BOTH;
                else if (sb)               st[b] = M_SET;
                else if (rb)               st[b] = M_RST;
                else if (st[b] == M_BOTH)  st[b] = M_INV;
            end
        end
        hist.push_front(enc());
        if (hist.size() > 4) void'(hist.pop_back());
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got q/qb/inv=%h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic clr, input logic en, input logic [7:0] s,
                        input logic [7:0] r);
        Clear  = clr;
        Enable = en;
        S_2D   = s;
        R_2D   = r;
        @(posedge Clk);
        model_edge(clr, en, s, r);
        #1;
        if (model_valid) begin
            chk("model_lat1", {q1, qb1, inv1}, hist[0]);
            chk("model_lat2", {q2, qb2, inv2}, hist[1]);
            chk("model_lat3", {q3, qb3, inv3}, hist[2]);
        end
    endtask

    typedef struct {
        logic       clr;
        logic       en;
        logic [7:0] s;
        logic [7:0] r;
        logic [3:0] q;
        logic [3:0] qb;
        logic [3:0] inv;
    } vec_t;
    vec_t tbl [$];

    task automatic add(input logic clr, input logic en, input logic [7:0] s, input logic [7:0] r,
                       input logic [3:0] q, input logic [3:0] qb, input logic [3:0] inv);
        vec_t v;
        v = '{clr, en, s, r, q, qb, inv};
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] rs, rr;
        Clear = 1'b0; Enable = 1'b0; S_2D = '0; R_2D = '0;
        repeat (2) @(posedge Clk);
        #1;

        // Expectations for LATENCY=2: each row shows the state formed one edge earlier.
        add(1, 1, 8'h00, 8'h00, 4'h0, 4'hF, 4'h0);
        add(0, 1, 8'h00, 8'h00, 4'h0, 4'hF, 4'h0);
        add(0, 1, 8'h10, 8'h00, 4'h0, 4'hF, 4'h0);
        add(0, 1, 8'h00, 8'h00, 4'h1, 4'hE, 4'h0);
        for (int i = 0; i < 5; i++) add(0, 1, 8'h00, 8'h00, 4'h1, 4'hE, 4'h0);
        add(0, 1, 8'h04, 8'h04, 4'h1, 4'hE, 4'h0);
        add(0, 1, 8'h00, 8'h00, 4'h1, 4'hA, 4'h0);
        add(0, 1, 8'h00, 8'h40, 4'h1, 4'hE, 4'h4);
        add(0, 1, 8'h00, 8'h00, 4'h1, 4'hE, 4'h0);
        for (int i = 0; i < 3; i++) add(0, 0, 8'hFF, 8'h00, 4'h1, 4'hE, 4'h0);
        add(0, 1, 8'hFF, 8'h00, 4'h1, 4'hE, 4'h0);
        add(0, 1, 8'h00, 8'h00, 4'hF, 4'h0, 4'h0);
        add(1, 0, 8'hFF, 8'h00, 4'h0, 4'hF, 4'h0);
        add(0, 1, 8'h22, 8'h00, 4'h0, 4'hF, 4'h0);
        add(0, 1, 8'h00, 8'h00, 4'h2, 4'hD, 4'h0);
        add(0, 1, 8'h08, 8'h02, 4'h2, 4'hD, 4'h0);
        add(0, 1, 8'h00, 8'h00, 4'h8, 4'h7, 4'h0);
        add(0, 1, 8'h00, 8'h00, 4'h8, 4'h7, 4'h0);

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].en, tbl[i].s, tbl[i].r);
            chk($sformatf("table_row%0d", i), {q2, qb2, inv2}, {tbl[i].q, tbl[i].qb, tbl[i].inv});
        end

        // LATENCY=3: a set in flight is flushed by Clear and never shows up.
        step(1, 1, 8'h00, 8'h00);
        step(0, 1, 8'h01, 8'h00);
        step(0, 1, 8'h00, 8'h00);
        chk("lat3_before_flush", {q3, qb3, inv3}, RST_WORD);
        step(1, 1, 8'h00, 8'h00);
        chk("lat3_clear_flush", {q3, qb3, inv3}, RST_WORD);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h00, 8'h00);
            chk($sformatf("lat3_flushed%0d", i), {q3, qb3, inv3}, RST_WORD);
        end

        // LATENCY=1: outputs follow the edge that sampled the input.
        step(0, 1, 8'h40, 8'h00);
        chk("lat1_set", {q1, qb1, inv1}, {4'h4, 4'hB, 4'h0});
        step(0, 1, 8'h00, 8'h04);
        chk("lat1_reset", {q1, qb1, inv1}, {4'h0, 4'hF, 4'h0});
        step(0, 1, 8'h01, 8'h10);
        chk("lat1_both", {q1, qb1, inv1}, {4'h0, 4'hE, 4'h0});
        step(0, 1, 8'h00, 8'h00);
        chk("lat1_invalid", {q1, qb1, inv1}, {4'h0, 4'hF, 4'h1});

        // Random traffic, model-checked on all three latencies.
        for (int n = 0; n < 400; n++) begin
            rs = 8'($urandom) & 8'($urandom);
            rr = 8'($urandom) & 8'($urandom);
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), rs, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
